ps2_keycode_rx: RTL and testbench

PS/2 keyboard receiver that deserialises scan-code frames from the keyboard's open-collector clock/data lines and maintains the 8-bit code of the most recently pressed, still-held key. Its `keycode` output drives the 8-bit `in_port` of the keycode PIO, which the Nios II software polls over Avalon-MM. Everything runs in the system clock domain. The PS/2 lines are asynchronous inputs and are synchronised internally.

---
 rtl/ps2_keycode_rx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises 11-bit frames
// and tracks the make code of the most recently pressed, still-held key.
module ps2_keycode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Synchronisers idle high so reset release with idle lines never fakes an edge
  logic [2:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          fall;
  logic          data_bit;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pending_q, ext_pending_d;
  logic          brk_pending_q, brk_pending_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          extended_q, extended_d;
  logic          byte_strobe_q, byte_strobe_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          frame_err_q, frame_err_d;
  logic          accept;
  logic          abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      ext_pending_q <= 1'b0;
      brk_pending_q <= 1'b0;
      keycode_q     <= 8'h00;
      extended_q    <= 1'b0;
      byte_strobe_q <= 1'b0;
      rx_byte_q     <= 8'h00;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      to_cnt_q      <= to_cnt_d;
      ext_pending_q <= ext_pending_d;
      brk_pending_q <= brk_pending_d;
      keycode_q     <= keycode_d;
      extended_q    <= extended_d;
      byte_strobe_q <= byte_strobe_d;
      rx_byte_q     <= rx_byte_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Frame FSM with inter-edge timeout; a fall in the same cycle beats the timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = to_cnt_q;
    accept    = 1'b0;
    abort     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall && !data_bit) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {data_bit, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_bit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (data_bit && (^{shift_q, parity_q})) begin
            accept = 1'b1;
          end else begin
            abort = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      state_d  = IDLE;
      abort    = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Scan-code decoder; pending prefix flags survive framing errors
  always_comb begin
    ext_pending_d = ext_pending_q;
    brk_pending_d = brk_pending_q;
    keycode_d     = keycode_q;
    extended_d    = extended_q;
    rx_byte_d     = rx_byte_q;
    byte_strobe_d = accept;
    frame_err_d   = abort;

    if (accept) begin
      rx_byte_d = shift_q;
      if (shift_q == 8'hE0) begin
        ext_pending_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pending_d = 1'b1;
      end else begin
        if (!brk_pending_q) begin
          keycode_d  = shift_q;
          extended_d = ext_pending_q;
        end else if ((shift_q == keycode_q) && (ext_pending_q == extended_q)) begin
          keycode_d  = 8'h00;
          extended_d = 1'b0;
        end
        ext_pending_d = 1'b0;
        brk_pending_d = 1'b0;
      end
    end
  end

  assign keycode     = keycode_q;
  assign extended    = extended_q;
  assign byte_strobe = byte_strobe_q;
  assign rx_byte     = rx_byte_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: directed frames push expected events,
// a monitor pops and compares on every byte_strobe / frame_err pulse.
module tb_ps2_keycode_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       extended;
  logic       byte_strobe;
  logic [7:0] rx_byte;
  logic       frame_err;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keycode(keycode),
    .extended(extended),
    .byte_strobe(byte_strobe),
    .rx_byte(rx_byte),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] b;
    logic [7:0] kc;
    logic       ext;
    int         lmin;
    int         lmax;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    logic       is_err;
    logic [7:0] kc;
    logic       ext;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic expect_ev(input logic is_err, input logic [7:0] b, input logic [7:0] kc,
                           input logic ext, input int lmin, input int lmax);
    exp_t e;
    e.is_err = is_err;
    e.b      = b;
    e.kc     = kc;
    e.ext    = ext;
    e.lmin   = lmin;
    e.lmax   = lmax;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_keycode"}, int'(keycode), 0);
    chk({tag, "_extended"}, int'(extended), 0);
    chk({tag, "_byte_strobe"}, int'(byte_strobe), 0);
    chk({tag, "_rx_byte"}, int'(rx_byte), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (reset_n && (byte_strobe || frame_err)) begin
      exp_t e;
      int   lat;
      lat = cyc - last_fall;
      checks++;
      if (byte_strobe && frame_err) begin
        errors++;
        $display("FAIL both_pulses: byte_strobe=1 frame_err=1 expected only one (t=%0t)", $time);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: strobe=%0b err=%0b rx_byte=0x%0h with nothing expected",
                 byte_strobe, frame_err, rx_byte);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_err", int'(frame_err), int'(e.is_err));
        if (!e.is_err) chk("rx_byte", int'(rx_byte), int'(e.b));
        chk("keycode", int'(keycode), int'(e.kc));
        chk("extended", int'(extended), int'(e.ext));
        chk_range("latency", lat, e.lmin, e.lmax);
        $display("event %s byte=0x%02h keycode=0x%02h ext=%0b latency=%0d",
                 frame_err ? "frame_err" : "byte", rx_byte, keycode, extended, lat);
      end
    end
  end

  initial begin
    vecs = '{
      '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},  // make
      '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},
      '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},  // released
      '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},
      '{8'h32, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},  // release of untracked key
      '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},  // typematic repeat
      '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},
      '{8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1},
      '{8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1},  // plain break, extended held
      '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1},
      '{8'h75, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
      '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},
      '{8'h1C, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0},  // bad parity
      '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0},  // bad stop
      '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0},
      '{8'h11, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0},  // error keeps E0 pending
      '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1}
    };

    reset_n = 1'b0;
    wait_cyc(3);
    check_idle_outputs("in_reset");
    reset_n = 1'b1;
    wait_cyc(5);
    check_idle_outputs("after_reset");

    foreach (vecs[i]) begin
      expect_ev(vecs[i].is_err, vecs[i].b, vecs[i].kc, vecs[i].ext, 3, 4);
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
    end

    // Timeout: start + 4 data bits of 0x1C, then the clock stops
    expect_ev(1'b1, 8'h00, 8'h11, 1'b1, 103, 104);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(150);
    expect_ev(1'b0, 8'h1C, 8'h1C, 1'b0, 3, 4);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Reset mid-frame after start + D0..D3 of 0x1C
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("pre_reset_keycode", int'(keycode), 8'h1C);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_frame_reset");
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
    // Remaining D4..stop = 1,0,0,0,0,1: the 0 after D4 looks like a start bit
    expect_ev(1'b1, 8'h00, 8'h00, 1'b0, 103, 104);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(150);
    expect_ev(1'b0, 8'h2B, 8'h2B, 1'b0, 3, 4);
    send_frame(8'h2B, 1'b0, 1'b0);

    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) wait_cyc(1);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_keycode", int'(keycode), 8'h2B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
